any1_issue_stage: RTL and testbench
===================================

// Module: any1_issue_stage
// PURPOSE
// - Consumer of the scheduler's selection: latches selected ROB index + entry, hands it to the execute unit via valid/ready.
// - Drives rob_pexec/rob_pexec2 back to the scheduler so in-flight entries are not reselected before ROB .out is set.
// - Pulses out_wr_o so the ROB marks the issued entry out; counts issued instructions.
// PARAMETERS
// - ROB_ENTRIES  from any1_pkg  ROB depth; must be <= 63 (index 63 is reserved as idle).
// - CNTW         32             width of issue counter.
// PORTS
// - rst_i          in   1        asynchronous, active-high reset
// - clk_i          in   1        single clock
// - flush_i        in   1        pipeline flush (mispredict/exception)
// - selection_i    in   7        scheduler output; bit6=1 means no selection, [5:0]=ROB index
// - sel_entry_i    in   sReorderEntry  rob[selection_i[5:0]], muxed by parent in same cycle
// - rob_pexec_o    out  6        index held in stage 1, 6'd63 when empty
// - rob_pexec2_o   out  6        index held in stage 2, 6'd63 when empty
// - exec_valid_o   out  1        stage 2 holds an instruction for execute
// - exec_ready_i   in   1        execute unit accepts this cycle
// - exec_entry_o   out  sReorderEntry  entry presented to execute
// - exec_rid_o     out  6        ROB index presented to execute
// - out_wr_o       out  1        one-cycle pulse: set rob[out_rid_o].out
// - out_rid_o      out  6        index for out_wr_o
// - issue_cnt_o    out  CNTW     count of completed execute handshakes
// BEHAVIOUR
// - Reset (async, rst_i=1): s1_v=s2_v=0, rob_pexec_o=rob_pexec2_o=63, exec_valid_o=0, out_wr_o=0,
//   out_rid_o=63, exec_rid_o=63, issue_cnt_o=0, exec_entry_o=0. Reset mid-operation discards all state.
// - Stages: s1 (latched selection), s2 (presented to execute). All outputs registered.
// - adv2 = !s2_v | exec_ready_i ; adv1 = s1_v & adv2 ; take = !selection_i[6] & (!s1_v | adv1).
// - Edge: if take, s1 <= {rid,entry}, s1_v<=1; else if adv1, s1_v<=0. If adv1, s2 <= s1, s2_v<=1;
//   else if s2_v & exec_ready_i, s2_v<=0.
// - Selection not taken (s1 stalled) is dropped; scheduler re-presents it (it is not excluded).
// - out_wr_o: registered; =1 for exactly the cycle after an s1->s2 transfer, out_rid_o=that rid.
//   Timeline: select@k, pexec@k+1, pexec2+out_wr@k+2, ROB .out visible @k+3; no window for reselection.
// - Stage-2 hold: exec_entry_o/exec_rid_o stable while exec_valid_o & !exec_ready_i (valid never drops unasked).
// - issue_cnt_o += 1 on exec_valid_o & exec_ready_i; wraps modulo 2^CNTW.
// - rob_pexec_o = s1_v ? s1_rid : 63 ; rob_pexec2_o = s2_v ? s2_rid : 63.
// - flush_i: next edge s1_v=s2_v=0, pexec outputs 63, out_wr_o=0; same-cycle selection ignored;
//   same-cycle handshake still counts (execute already accepted). Flush has priority over take/adv.
// - Selection with index 63 and bit6=0 is illegal (assertion).
// - Back-to-back: with exec_ready_i held 1, one instruction issues per cycle, latency select->exec_valid = 2 edges.
// STRUCTURE
// - any1_pkg: sReorderEntry, ROB_ENTRIES (existing); add NO_RID = 6'd63, NO_SEL = 7'h7F.
// - Single module, no sub-modules; pipeline regs coded as two packed stage structs (rid, entry, v).
// - Elaboration-time check ROB_ENTRIES <= 63.
// TESTING
// - Reset: assert rst_i mid-stream with s1,s2 full -> all outputs at reset values same cycle, counter 0.
// - Single issue: selection=7'h05 one cycle, ready=1 -> pexec=5 @+1, exec_valid,rid=5,out_wr,out_rid=5 @+2, cnt=1.
// - Stall: sel 3,4,5 on consecutive cycles, ready=0 -> s2=3, s1=4, sel 5 dropped; pexec=4,pexec2=3; ready=1 -> 3 then 4 issue, out_wr once each.
// - Streaming: sel 0..9 each cycle, ready=1 -> rids 0..9 on exec in order, no bubbles, cnt=10.
// - Flush: s1=7,s2=6 valid, flush_i with selection=8 -> next cycle pexec=pexec2=63, exec_valid=0, 8 not captured.
// - Idle: selection=7'h7F forever -> exec_valid=0, out_wr=0, pexec outputs 63, counter unchanged.

Source files
------------

// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared ROB types and constants for the any1 core
package any1_pkg;

    // ROB depth; index 63 is reserved as the idle marker, so depth is capped at 63.
    localparam int ROB_ENTRIES = 32;

    localparam logic [5:0] NO_RID = 6'd63;
    localparam logic [6:0] NO_SEL = 7'h7F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [5:0]  tgt;
        logic        done;
        logic        out;
    } sReorderEntry;

    // One issue pipeline stage: valid flag, ROB index and the captured entry.
    typedef struct packed {
        logic         v;
        logic [5:0]   rid;
        sReorderEntry entry;
    } issue_stage_t;

    localparam issue_stage_t STAGE_IDLE = '{v: 1'b0, rid: NO_RID, entry: '0};

endpackage

// File: rtl/any1_issue_stage.sv
// rtl/any1_issue_stage.sv - two-stage issue pipe between scheduler and execute
//
// Ports:
//   rst_i, clk_i         async active-high reset, clock
//   flush_i              drop everything in flight
//   selection_i          scheduler pick: bit6=1 idle, [5:0] ROB index
//   sel_entry_i          ROB entry for selection_i[5:0]
//   rob_pexec_o          stage-1 index (63 when empty)
//   rob_pexec2_o         stage-2 index (63 when empty)
//   exec_valid_o/ready_i handshake with execute
//   exec_entry_o/rid_o   entry and index presented to execute
//   out_wr_o/out_rid_o   one-cycle request to set rob[out_rid_o].out
//   issue_cnt_o          count of accepted issues, wraps
module any1_issue_stage
    import any1_pkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic             rst_i,
    input  logic             clk_i,
    input  logic             flush_i,
    input  logic [6:0]       selection_i,
    input  sReorderEntry     sel_entry_i,
    output logic [5:0]       rob_pexec_o,
    output logic [5:0]       rob_pexec2_o,
    output logic             exec_valid_o,
    input  logic             exec_ready_i,
    output sReorderEntry     exec_entry_o,
    output logic [5:0]       exec_rid_o,
    output logic             out_wr_o,
    output logic [5:0]       out_rid_o,
    output logic [CNTW-1:0]  issue_cnt_o
);

    if (ROB_ENTRIES > 63) begin : g_rob_too_deep
        $error("ROB_ENTRIES must be <= 63; index 63 is the idle marker");
    end

    issue_stage_t    s1;
    issue_stage_t    s2;
    logic [CNTW-1:0] cnt;
    logic            adv1;
    logic            adv2;
    logic            take;
    logic            hs;

    always_comb begin
        adv2 = !s2.v || exec_ready_i;
        adv1 = s1.v && adv2;
        // A selection arriving while s1 is stuck is simply dropped; the scheduler
        // will pick it again because its .out bit is still clear.
        take = !selection_i[6] && (!s1.v || adv1);
        hs   = s2.v && exec_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1        <= STAGE_IDLE;
            s2        <= STAGE_IDLE;
            out_wr_o  <= 1'b0;
            out_rid_o <= NO_RID;
            cnt       <= '0;
        end else begin
            // Execute has already accepted on a handshake, so it counts even under flush.
            if (hs) begin
                cnt <= cnt + 1'b1;
            end
            out_wr_o <= 1'b0;
            if (flush_i) begin
                s1.v <= 1'b0;
                s2.v <= 1'b0;
            end else begin
                if (take) begin
                    s1.v     <= 1'b1;
                    s1.rid   <= selection_i[5:0];
                    s1.entry <= sel_entry_i;
                end else if (adv1) begin
                    s1.v <= 1'b0;
                end
                if (adv1) begin
                    s2        <= s1;
                    // Marking .out as the entry enters s2 lands in the ROB the cycle
                    // after pexec2 takes over, so the scheduler never sees a gap.
                    out_wr_o  <= 1'b1;
                    out_rid_o <= s1.rid;
                end else if (hs) begin
                    s2.v <= 1'b0;
                end
            end
        end
    end

    assign rob_pexec_o  = s1.v ? s1.rid : NO_RID;
    assign rob_pexec2_o = s2.v ? s2.rid : NO_RID;
    assign exec_valid_o = s2.v;
    assign exec_rid_o   = s2.rid;
    assign exec_entry_o = s2.entry;
    assign issue_cnt_o  = cnt;

    a_no_illegal_sel: assert property (@(posedge clk_i) disable iff (rst_i)
        selection_i != {1'b0, NO_RID});

endmodule

// File: tb/tb_any1_issue_stage.sv
// tb/tb_any1_issue_stage.sv - self-checking bench for any1_issue_stage
module tb_any1_issue_stage;
    import any1_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [6:0]       selection = NO_SEL;
    sReorderEntry     sel_entry = '0;
    logic             exec_ready = 1'b0;
    logic [5:0]       rob_pexec;
    logic [5:0]       rob_pexec2;
    logic             exec_valid;
    sReorderEntry     exec_entry;
    logic [5:0]       exec_rid;
    logic             out_wr;
    logic [5:0]       out_rid;
    logic [31:0]      issue_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    any1_issue_stage #(.CNTW(32)) dut (
        .rst_i        (rst),
        .clk_i        (clk),
        .flush_i      (flush),
        .selection_i  (selection),
        .sel_entry_i  (sel_entry),
        .rob_pexec_o  (rob_pexec),
        .rob_pexec2_o (rob_pexec2),
        .exec_valid_o (exec_valid),
        .exec_ready_i (exec_ready),
        .exec_entry_o (exec_entry),
        .exec_rid_o   (exec_rid),
        .out_wr_o     (out_wr),
        .out_rid_o    (out_rid),
        .issue_cnt_o  (issue_cnt)
    );

    function automatic sReorderEntry mk_entry(input logic [5:0] rid);
        sReorderEntry e;
        e.pc   = 32'h0000_1000 + {24'd0, rid, 2'b00};
        e.ir   = 32'hA500_0000 | {26'd0, rid};
        e.tgt  = rid ^ 6'h2A;
        e.done = rid[0];
        e.out  = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pipe holds at most one waiting instruction (scheduler side) and
    // at most one shown to execute. Plain queues, updated once per clock edge.
    typedef struct {
        logic [5:0]   rid;
        sReorderEntry e;
    } item_t;

    item_t       waiting_q[$];
    item_t       shown_q[$];
    bit          m_out_wr  = 1'b0;
    logic [5:0]  m_out_rid = NO_RID;
    logic [31:0] m_cnt     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            waiting_q.delete();
            shown_q.delete();
            m_out_wr  = 1'b0;
            m_out_rid = NO_RID;
            m_cnt     = '0;
        end else begin
            bit    accepted;
            bit    room;
            item_t it;
            accepted = (shown_q.size() != 0) && exec_ready;
            room     = (shown_q.size() == 0) || exec_ready;
            if (accepted) m_cnt = m_cnt + 32'd1;
            m_out_wr = 1'b0;
            if (flush) begin
                waiting_q.delete();
                shown_q.delete();
            end else begin
                if (accepted) shown_q.delete(0);
                if (room && waiting_q.size() != 0) begin
                    it = waiting_q.pop_front();
                    shown_q.push_back(it);
                    m_out_wr  = 1'b1;
                    m_out_rid = it.rid;
                end
                if (!selection[6] && waiting_q.size() == 0) begin
                    it.rid = selection[5:0];
                    it.e   = sel_entry;
                    waiting_q.push_back(it);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("exec_valid", {71'd0, exec_valid}, {71'd0, shown_q.size() != 0});
            check("rob_pexec", {66'd0, rob_pexec},
                  {66'd0, (waiting_q.size() != 0) ? waiting_q[0].rid : NO_RID});
            check("rob_pexec2", {66'd0, rob_pexec2},
                  {66'd0, (shown_q.size() != 0) ? shown_q[0].rid : NO_RID});
            if (shown_q.size() != 0) begin
                check("exec_rid", {66'd0, exec_rid}, {66'd0, shown_q[0].rid});
                check("exec_entry", exec_entry, shown_q[0].e);
            end
            check("out_wr", {71'd0, out_wr}, {71'd0, m_out_wr});
            if (m_out_wr) check("out_rid", {66'd0, out_rid}, {66'd0, m_out_rid});
            check("issue_cnt", {40'd0, issue_cnt}, {40'd0, m_cnt});
        end
    end

    task automatic step(input logic [6:0] sel, input logic rdy, input logic fl);
        @(negedge clk);
        selection  = sel;
        sel_entry  = mk_entry(sel[5:0]);
        exec_ready = rdy;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pexec"},   {66'd0, rob_pexec},  {66'd0, NO_RID});
        check({tag, "_pexec2"},  {66'd0, rob_pexec2}, {66'd0, NO_RID});
        check({tag, "_valid"},   {71'd0, exec_valid}, 72'd0);
        check({tag, "_out_wr"},  {71'd0, out_wr},     72'd0);
        check({tag, "_out_rid"}, {66'd0, out_rid},    {66'd0, NO_RID});
        check({tag, "_rid"},     {66'd0, exec_rid},   {66'd0, NO_RID});
        check({tag, "_entry"},   exec_entry,          72'd0);
        check({tag, "_cnt"},     {40'd0, issue_cnt},  72'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        // Idle
        repeat (5) step(NO_SEL, 1'b1, 1'b0);
        check("idle_cnt", {40'd0, issue_cnt}, 72'd0);

        // Single issue
        step(7'h05, 1'b1, 1'b0);
        check("single_pexec", {66'd0, rob_pexec}, 72'd5);
        check("single_valid_early", {71'd0, exec_valid}, 72'd0);
        step(NO_SEL, 1'b1, 1'b0);
        check("single_valid", {71'd0, exec_valid}, 72'd1);
        check("single_rid", {66'd0, exec_rid}, 72'd5);
        check("single_out_wr", {71'd0, out_wr}, 72'd1);
        check("single_out_rid", {66'd0, out_rid}, 72'd5);
        check("single_pexec2", {66'd0, rob_pexec2}, 72'd5);
        step(NO_SEL, 1'b1, 1'b0);
        check("single_cnt", {40'd0, issue_cnt}, 72'd1);
        check("single_out_wr_pulse", {71'd0, out_wr}, 72'd0);

        // Stall: 5 is dropped
        step(7'h03, 1'b0, 1'b0);
        step(7'h04, 1'b0, 1'b0);
        step(7'h05, 1'b0, 1'b0);
        check("stall_pexec", {66'd0, rob_pexec}, 72'd4);
        check("stall_pexec2", {66'd0, rob_pexec2}, 72'd3);
        check("stall_rid", {66'd0, exec_rid}, 72'd3);
        step(NO_SEL, 1'b1, 1'b0);
        check("stall_rid2", {66'd0, exec_rid}, 72'd4);
        check("stall_out_rid", {66'd0, out_rid}, 72'd4);
        check("stall_cnt1", {40'd0, issue_cnt}, 72'd2);
        step(NO_SEL, 1'b1, 1'b0);
        check("stall_cnt2", {40'd0, issue_cnt}, 72'd3);
        check("stall_drop", {71'd0, exec_valid}, 72'd0);
        check("stall_drop_pexec", {66'd0, rob_pexec}, {66'd0, NO_RID});

        // Streaming 0..9
        for (int i = 0; i < 10; i++) step({1'b0, 6'(i)}, 1'b1, 1'b0);
        repeat (2) step(NO_SEL, 1'b1, 1'b0);
        check("stream_cnt", {40'd0, issue_cnt}, 72'd13);

        // Flush with s1=7, s2=6, selection 8 ignored
        step(7'h06, 1'b0, 1'b0);
        step(7'h07, 1'b0, 1'b0);
        check("fl_pre_pexec", {66'd0, rob_pexec}, 72'd7);
        check("fl_pre_pexec2", {66'd0, rob_pexec2}, 72'd6);
        step(7'h08, 1'b0, 1'b1);
        check("fl_pexec", {66'd0, rob_pexec}, {66'd0, NO_RID});
        check("fl_pexec2", {66'd0, rob_pexec2}, {66'd0, NO_RID});
        check("fl_valid", {71'd0, exec_valid}, 72'd0);
        repeat (3) step(NO_SEL, 1'b1, 1'b0);
        check("fl_cnt", {40'd0, issue_cnt}, 72'd13);

        // Flush coinciding with an accepted handshake still counts
        step(7'h06, 1'b0, 1'b0);
        step(7'h07, 1'b0, 1'b0);
        step(7'h08, 1'b1, 1'b1);
        check("flhs_cnt", {40'd0, issue_cnt}, 72'd14);
        check("flhs_valid", {71'd0, exec_valid}, 72'd0);

        // Reset mid-stream with both stages full
        step(7'h01, 1'b0, 1'b0);
        step(7'h02, 1'b0, 1'b0);
        @(negedge clk);
        selection = NO_SEL;
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid");
        @(negedge clk);
        rst = 1'b0;

        // Long idle
        repeat (20) step(NO_SEL, 1'b1, 1'b0);
        check("idle2_cnt", {40'd0, issue_cnt}, 72'd0);
        check("idle2_pexec", {66'd0, rob_pexec}, {66'd0, NO_RID});

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
